// File: rtl/z_buffer_arbiter.sv
// Depth-buffer arbiter: owns the Z RAM, sweeps the full-screen clear, and serialises
// depth-test read-compare-write transactions against display readback on the read port.
module z_buffer_arbiter #(
  parameter int              SCREEN_W  = 320,
  parameter int              SCREEN_H  = 240,
  parameter int              ADDR_W    = 17,
  parameter int              Z_W       = 16,
  parameter logic [Z_W-1:0]  CLEAR_VAL = 16'hFFFF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              frame_start_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  input  logic              dt_req_i,
  input  logic [8:0]        dt_x_i,
  input  logic [7:0]        dt_y_i,
  input  logic [Z_W-1:0]    dt_z_i,
  output logic              dt_gnt_o,
  output logic              dt_resp_valid_o,
  output logic              dt_pass_o,
  input  logic              rb_req_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic              rb_gnt_o,
  output logic              rb_valid_o,
  output logic [Z_W-1:0]    rb_data_o,
  output logic [ADDR_W-1:0] ram_addra_o,
  output logic [Z_W-1:0]    ram_dina_o,
  output logic              ram_wea_o,
  output logic [ADDR_W-1:0] ram_addrb_o,
  input  logic [Z_W-1:0]    ram_doutb_i
);

  localparam int NUM_PIX = SCREEN_W * SCREEN_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] END_CNT   = ADDR_W'(NUM_PIX);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_DT_RD, S_DT_CMP, S_RB_RD, S_RB_OUT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              clear_pend, clear_pend_nxt;
  logic              rr_rb, rr_rb_nxt;
  logic [ADDR_W-1:0] dt_addr, dt_addr_nxt;
  logic [Z_W-1:0]    dt_z, dt_z_nxt;
  logic              dt_ok, dt_ok_nxt;
  logic              rb_ok, rb_ok_nxt;

  logic              clear_busy_nxt, clear_done_nxt;
  logic              dt_resp_valid_nxt, dt_pass_nxt;
  logic              rb_valid_nxt;
  logic [Z_W-1:0]    rb_data_nxt;
  logic [ADDR_W-1:0] ram_addra_nxt, ram_addrb_nxt;
  logic [Z_W-1:0]    ram_dina_nxt;
  logic              ram_wea_nxt;

  logic              clear_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in_range;
  logic              rb_in_range;

  assign clear_req    = clear_pend | frame_start_i;
  assign pix_addr     = ADDR_W'(dt_y_i) * ADDR_W'(SCREEN_W) + ADDR_W'(dt_x_i);
  assign pix_in_range = (32'(dt_x_i) < SCREEN_W) && (32'(dt_y_i) < SCREEN_H);
  assign rb_in_range  = 32'(rb_addr_i) < NUM_PIX;

  // A pending clear blocks both requesters; on contention the round-robin bit picks.
  assign dt_gnt_o = (state == S_IDLE) && !clear_req && dt_req_i && (!rb_req_i || !rr_rb);
  assign rb_gnt_o = (state == S_IDLE) && !clear_req && rb_req_i && (!dt_req_i || rr_rb);

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    clear_pend_nxt    = clear_pend | frame_start_i;
    rr_rb_nxt         = rr_rb;
    dt_addr_nxt       = dt_addr;
    dt_z_nxt          = dt_z;
    dt_ok_nxt         = dt_ok;
    rb_ok_nxt         = rb_ok;
    clear_busy_nxt    = clear_busy_o;
    clear_done_nxt    = 1'b0;
    dt_resp_valid_nxt = 1'b0;
    dt_pass_nxt       = 1'b0;
    rb_valid_nxt      = 1'b0;
    rb_data_nxt       = rb_data_o;
    ram_addra_nxt     = ram_addra_o;
    ram_dina_nxt      = ram_dina_o;
    ram_wea_nxt       = 1'b0;
    ram_addrb_nxt     = ram_addrb_o;

    case (state)
      S_CLEAR: begin
        // A new frame request mid-sweep restarts from address 0 without a done pulse;
        // the extra cnt==END_CNT cycle lets busy drop one cycle after the last write.
        clear_pend_nxt = 1'b0;
        if (frame_start_i) begin
          cnt_nxt = '0;
        end else if (cnt == END_CNT) begin
          state_nxt      = S_IDLE;
          clear_busy_nxt = 1'b0;
        end else begin
          ram_wea_nxt    = 1'b1;
          ram_addra_nxt  = cnt;
          ram_dina_nxt   = CLEAR_VAL;
          clear_done_nxt = (cnt == LAST_ADDR);
          cnt_nxt        = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (clear_req) begin
          state_nxt      = S_CLEAR;
          cnt_nxt        = '0;
          clear_busy_nxt = 1'b1;
          clear_pend_nxt = 1'b0;
        end else if (dt_gnt_o) begin
          state_nxt   = S_DT_RD;
          rr_rb_nxt   = ~rr_rb;
          dt_addr_nxt = pix_addr;
          dt_z_nxt    = dt_z_i;
          dt_ok_nxt   = pix_in_range;
          if (pix_in_range) ram_addrb_nxt = pix_addr;
        end else if (rb_gnt_o) begin
          state_nxt     = S_RB_RD;
          rr_rb_nxt     = ~rr_rb;
          rb_ok_nxt     = rb_in_range;
          ram_addrb_nxt = rb_addr_i;
        end
      end
      S_DT_RD: state_nxt = S_DT_CMP;
      S_DT_CMP: begin
        state_nxt         = S_IDLE;
        dt_resp_valid_nxt = 1'b1;
        if (dt_ok && (dt_z <= ram_doutb_i)) begin
          dt_pass_nxt   = 1'b1;
          ram_wea_nxt   = 1'b1;
          ram_addra_nxt = dt_addr;
          ram_dina_nxt  = dt_z;
        end
      end
      S_RB_RD: state_nxt = S_RB_OUT;
      S_RB_OUT: begin
        state_nxt    = S_IDLE;
        rb_valid_nxt = 1'b1;
        rb_data_nxt  = rb_ok ? ram_doutb_i : '0;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= S_CLEAR;
      cnt             <= '0;
      clear_pend      <= 1'b0;
      rr_rb           <= 1'b0;
      dt_addr         <= '0;
      dt_z            <= '0;
      dt_ok           <= 1'b0;
      rb_ok           <= 1'b0;
      clear_busy_o    <= 1'b1;
      clear_done_o    <= 1'b0;
      dt_resp_valid_o <= 1'b0;
      dt_pass_o       <= 1'b0;
      rb_valid_o      <= 1'b0;
      rb_data_o       <= '0;
      ram_addra_o     <= '0;
      ram_dina_o      <= '0;
      ram_wea_o       <= 1'b0;
      ram_addrb_o     <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      clear_pend      <= clear_pend_nxt;
      rr_rb           <= rr_rb_nxt;
      dt_addr         <= dt_addr_nxt;
      dt_z            <= dt_z_nxt;
      dt_ok           <= dt_ok_nxt;
      rb_ok           <= rb_ok_nxt;
      clear_busy_o    <= clear_busy_nxt;
      clear_done_o    <= clear_done_nxt;
      dt_resp_valid_o <= dt_resp_valid_nxt;
      dt_pass_o       <= dt_pass_nxt;
      rb_valid_o      <= rb_valid_nxt;
      rb_data_o       <= rb_data_nxt;
      ram_addra_o     <= ram_addra_nxt;
      ram_dina_o      <= ram_dina_nxt;
      ram_wea_o       <= ram_wea_nxt;
      ram_addrb_o     <= ram_addrb_nxt;
    end
  end

endmodule

// File: tb/tb_z_buffer_arbiter.sv
// Scoreboard bench for z_buffer_arbiter on a reduced screen so full clear sweeps stay short.
module tb_z_buffer_arbiter;

  localparam int W   = 40;
  localparam int H   = 24;
  localparam int NUM = W * H;

  typedef struct { logic [16:0] addr; logic [15:0] data; bit clr; int cyc; } wr_exp_t;
  typedef struct { bit pass; int cyc; } dt_exp_t;
  typedef struct { logic [15:0] data; int cyc; } rb_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        clear_busy, clear_done;
  logic        dt_req;
  logic [8:0]  dt_x;
  logic [7:0]  dt_y;
  logic [15:0] dt_z;
  logic        dt_gnt, dt_resp_valid, dt_pass;
  logic        rb_req;
  logic [16:0] rb_addr;
  logic        rb_gnt, rb_valid;
  logic [15:0] rb_data;
  logic [16:0] ram_addra, ram_addrb;
  logic [15:0] ram_dina, ram_doutb;
  logic        ram_wea;

  logic [15:0] ram [0:131071];
  logic [15:0] exp_mem [NUM];
  wr_exp_t     wr_q[$];
  dt_exp_t     dt_q[$];
  rb_exp_t     rb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_clr_cyc = 0;
  bit rr_model = 1'b0;

  z_buffer_arbiter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .frame_start_i(frame_start),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .dt_req_i(dt_req), .dt_x_i(dt_x), .dt_y_i(dt_y), .dt_z_i(dt_z),
    .dt_gnt_o(dt_gnt), .dt_resp_valid_o(dt_resp_valid), .dt_pass_o(dt_pass),
    .rb_req_i(rb_req), .rb_addr_i(rb_addr), .rb_gnt_o(rb_gnt),
    .rb_valid_o(rb_valid), .rb_data_o(rb_data),
    .ram_addra_o(ram_addra), .ram_dina_o(ram_dina), .ram_wea_o(ram_wea),
    .ram_addrb_o(ram_addrb), .ram_doutb_i(ram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple dual-port RAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_wea) ram[ram_addra] <= ram_dina;
    ram_doutb <= ram[ram_addrb];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT presents a write or a result.
  wr_exp_t we;
  dt_exp_t de;
  rb_exp_t re;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_wea) begin
        if (wr_q.size() == 0) check_output("unexp_write", 32'(ram_wea), 32'd0);
        else begin
          we = wr_q.pop_front();
          check_output("wr_addr", 32'(ram_addra), 32'(we.addr));
          check_output("wr_data", 32'(ram_dina), 32'(we.data));
          if (!we.clr) check_output("wr_cycle", cyc, we.cyc);
          else if (we.addr != 0) check_output("clr_consec", cyc, last_clr_cyc + 1);
          if (we.clr) last_clr_cyc = cyc;
        end
      end
      if (clear_done) begin
        done_cnt++;
        check_output("done_addr", 32'(ram_addra), NUM - 1);
        check_output("done_wea", 32'(ram_wea), 32'd1);
      end
      if (dt_resp_valid) begin
        if (dt_q.size() == 0) check_output("unexp_dt_resp", 32'(dt_resp_valid), 32'd0);
        else begin
          de = dt_q.pop_front();
          check_output("dt_pass", 32'(dt_pass), 32'(de.pass));
          check_output("dt_cycle", cyc, de.cyc);
        end
      end
      if (rb_valid) begin
        if (rb_q.size() == 0) check_output("unexp_rb_valid", 32'(rb_valid), 32'd0);
        else begin
          re = rb_q.pop_front();
          check_output("rb_data", 32'(rb_data), 32'(re.data));
          check_output("rb_cycle", cyc, re.cyc);
        end
      end
      if (clear_busy && (dt_req || rb_req))
        check_output("gnt_in_clear", 32'({dt_gnt, rb_gnt}), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int i = 0; i < NUM; i++) begin
      wr_q.push_back('{addr: 17'(i), data: 16'hFFFF, clr: 1'b1, cyc: -1});
      exp_mem[i] = 16'hFFFF;
    end
  endtask

  task automatic wait_clear(input int exp_done);
    for (int k = 0; k < NUM + 300; k++) begin
      if (!clear_busy) break;
      tick();
    end
    check_output("clear_finished", 32'(clear_busy), 32'd0);
    check_output("clear_q_drained", wr_q.size(), 32'd0);
    check_output("done_count", done_cnt, exp_done);
  endtask

  task automatic wait_any(output int g);
    g = -1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (dt_gnt || rb_gnt) begin
        g = cyc;
        break;
      end
      @(posedge clk);
    end
    check_output("grant_seen", 32'(g >= 0), 32'd1);
  endtask

  task automatic apply_stimulus_dt(input int x, input int y, input logic [15:0] z);
    int  g;
    int  a;
    bit  ok;
    bit  p;
    ok = (x < W) && (y < H);
    a  = y * W + x;
    p  = ok && (z <= exp_mem[ok ? a : 0]);
    dt_x = 9'(x); dt_y = 8'(y); dt_z = z; dt_req = 1'b1;
    wait_any(g);
    check_output("dt_gnt_only", 32'({dt_gnt, rb_gnt}), 32'b10);
    dt_q.push_back('{pass: p, cyc: g + 3});
    if (p) begin
      wr_q.push_back('{addr: 17'(a), data: z, clr: 1'b0, cyc: g + 3});
      exp_mem[a] = z;
    end
    rr_model = ~rr_model;
    tick();
    #1;
    check_output("dt_gnt_once", 32'(dt_gnt), 32'd0);
    dt_req = 1'b0;
  endtask

  task automatic apply_stimulus_rb(input int a);
    int g;
    logic [15:0] e;
    e = (a < NUM) ? exp_mem[a] : 16'h0000;
    rb_addr = 17'(a); rb_req = 1'b1;
    wait_any(g);
    check_output("rb_gnt_only", 32'({dt_gnt, rb_gnt}), 32'b01);
    rb_q.push_back('{data: e, cyc: g + 3});
    rr_model = ~rr_model;
    tick();
    #1;
    check_output("rb_gnt_once", 32'(rb_gnt), 32'd0);
    rb_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_done;
    int g;
    int prev_g;
    logic [16:0] pre_addrb;
    logic [15:0] az;

    for (int i = 0; i < 131072; i++) ram[i] = 16'h5A5A;
    reset_n = 1'b0; frame_start = 1'b0;
    dt_req = 1'b0; dt_x = '0; dt_y = '0; dt_z = '0;
    rb_req = 1'b0; rb_addr = '0;
    exp_done = 0;
    tick(); tick();

    check_output("rst_busy", 32'(clear_busy), 32'd1);
    check_output("rst_done", 32'(clear_done), 32'd0);
    check_output("rst_wea", 32'(ram_wea), 32'd0);
    check_output("rst_resp", 32'(dt_resp_valid), 32'd0);
    check_output("rst_rbv", 32'(rb_valid), 32'd0);
    check_output("rst_addrb", 32'(ram_addrb), 32'd0);

    // Power-up clear sweep.
    push_clear();
    rr_model = 1'b0;
    reset_n  = 1'b1;
    tick();
    check_output("first_clear_wea", 32'(ram_wea), 32'd1);
    exp_done++;
    wait_clear(exp_done);

    // Pass, fail, then equality on the same pixel.
    apply_stimulus_dt(5, 2, 16'h1000);
    apply_stimulus_dt(5, 2, 16'h2000);
    apply_stimulus_dt(5, 2, 16'h1000);
    apply_stimulus_dt(W - 1, H - 1, 16'h0000);
    pre_addrb = ram_addrb;
    apply_stimulus_dt(W, 0, 16'h0010);
    check_output("oor_addrb_hold", 32'(ram_addrb), 32'(pre_addrb));
    apply_stimulus_dt(0, H, 16'h0010);

    apply_stimulus_rb(2 * W + 5);
    apply_stimulus_rb(NUM - 1);
    apply_stimulus_rb(NUM + 5);
    apply_stimulus_rb(0);

    // Both requesters held: grants alternate every third cycle.
    dt_x = 9'd7; dt_y = 8'd3; rb_addr = 17'(3 * W + 7);
    az = 16'h0800;
    dt_z = az;
    dt_req = 1'b1; rb_req = 1'b1;
    prev_g = 0;
    for (int i = 0; i < 6; i++) begin
      wait_any(g);
      check_output("alt_who_dt", 32'(dt_gnt), 32'(!rr_model));
      check_output("alt_who_rb", 32'(rb_gnt), 32'(rr_model));
      if (i > 0) check_output("alt_spacing", g - prev_g, 32'd3);
      prev_g = g;
      if (dt_gnt) begin
        dt_q.push_back('{pass: (az <= exp_mem[3 * W + 7]), cyc: g + 3});
        if (az <= exp_mem[3 * W + 7]) begin
          wr_q.push_back('{addr: 17'(3 * W + 7), data: az, clr: 1'b0, cyc: g + 3});
          exp_mem[3 * W + 7] = az;
        end
      end else begin
        rb_q.push_back('{data: exp_mem[3 * W + 7], cyc: g + 3});
      end
      rr_model = ~rr_model;
      tick();
      az   = az - 16'h0010;
      dt_z = az;
    end
    dt_req = 1'b0; rb_req = 1'b0;

    // Frame start while a depth test is in DT_RD, then a restart 100 cycles into the clear.
    apply_stimulus_dt(10, 4, 16'h0100);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    push_clear();
    tick();
    tick();
    check_output("fs_busy_rise", 32'(clear_busy), 32'd1);
    dt_req = 1'b1; rb_req = 1'b1;
    for (int i = 0; i < 96; i++) tick();
    dt_req = 1'b0; rb_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_q.delete();
    push_clear();
    exp_done++;
    wait_clear(exp_done);

    // Reset pulse in the middle of a clear.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    push_clear();
    for (int i = 0; i < 50; i++) tick();
    reset_n = 1'b0;
    #1;
    check_output("rclr_busy", 32'(clear_busy), 32'd1);
    check_output("rclr_wea", 32'(ram_wea), 32'd0);
    check_output("rclr_addra", 32'(ram_addra), 32'd0);
    tick();
    reset_n = 1'b1;
    wr_q.delete();
    push_clear();
    rr_model = 1'b0;
    exp_done++;
    wait_clear(exp_done);

    // Reset pulse in the middle of a depth-test transaction.
    apply_stimulus_dt(1, 1, 16'h0001);
    reset_n = 1'b0;
    #1;
    check_output("rtx_resp", 32'(dt_resp_valid), 32'd0);
    check_output("rtx_busy", 32'(clear_busy), 32'd1);
    dt_q.delete();
    wr_q.delete();
    tick();
    reset_n = 1'b1;
    push_clear();
    rr_model = 1'b0;
    exp_done++;
    wait_clear(exp_done);

    apply_stimulus_dt(1, 1, 16'h0001);
    apply_stimulus_rb(W + 1);
    for (int i = 0; i < 6; i++) tick();
    check_output("end_dt_q", dt_q.size(), 32'd0);
    check_output("end_rb_q", rb_q.size(), 32'd0);
    check_output("end_wr_q", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
